// File: rtl/uart_pkg.sv
// Shared UART definitions: default word width, oversampling ratio and FIFO
// sizing, plus a helper for sizing FIFO pointers.
package uart_pkg;

    localparam int unsigned DefaultDataLength      = 8;
    localparam int unsigned DefaultOverSample      = 8;
    localparam int unsigned DefaultDepth           = 16;
    localparam int unsigned DefaultAlmostFullLevel = 12;

    // Pointer width for a FIFO of the given depth: address bits plus one
    // wrap bit so that full and empty can be told apart.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Flop-array storage for the UART FIFOs: one synchronous write port and one
// asynchronous (combinational) read port.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DataLength = DefaultDataLength,
    parameter int unsigned Depth      = DefaultDepth,
    parameter int unsigned AddrWidth  = $clog2(Depth)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic [AddrWidth-1:0]  i_wr_addr,
    input  logic [DataLength-1:0] i_wr_data,
    input  logic [AddrWidth-1:0]  i_rd_addr,
    output logic [DataLength-1:0] o_rd_data
);

    logic [DataLength-1:0] mem [Depth];

    // Store the incoming word at the write address; reset wipes every entry.
    // NOTE: the array is reset on purpose so o_rd_data reads 0 after reset and
    // no old frame survives a mid-burst reset; this keeps it in flops, not RAM.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through FIFO between the bus side and the UART transmitter.
// The head word sits on o_rd_data whenever o_empty is low; i_rd_en pops it.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DataLength      = DefaultDataLength,
    parameter int unsigned Depth           = DefaultDepth,
    parameter int unsigned AlmostFullLevel = DefaultAlmostFullLevel
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [DataLength-1:0]    i_wr_data,
    input  logic                     i_wr_en,
    output logic                     o_full,
    output logic                     o_almost_full,
    output logic [DataLength-1:0]    o_rd_data,
    output logic                     o_empty,
    input  logic                     i_rd_en,
    output logic [$clog2(Depth):0]   o_count,
    output logic                     o_overflow,
    output logic                     o_underflow,
    input  logic                     i_clear_flags
);

    localparam int unsigned PtrWidth  = ptr_width(Depth);
    localparam int unsigned AddrWidth = PtrWidth - 1;

    if ((Depth < 2) || ((Depth & (Depth - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "uart_tx_fifo: Depth must be a power of two >= 2");
    end
    if ((AlmostFullLevel < 1) || (AlmostFullLevel > Depth)) begin : g_bad_level
        $fatal(1, "uart_tx_fifo: AlmostFullLevel must be in 1..Depth");
    end

    logic [PtrWidth-1:0] wr_ptr;
    logic [PtrWidth-1:0] rd_ptr;
    logic                pop_ok;
    logic                wr_ok;

    // Status is purely a function of the registered pointers.
    assign o_count       = wr_ptr - rd_ptr;
    assign o_empty       = (wr_ptr == rd_ptr);
    assign o_full        = (wr_ptr[AddrWidth-1:0] == rd_ptr[AddrWidth-1:0]) &&
                           (wr_ptr[PtrWidth-1] != rd_ptr[PtrWidth-1]);
    assign o_almost_full = (o_count >= PtrWidth'(AlmostFullLevel));

    // A pop frees a slot this cycle, so a write while full is taken if a real
    // pop happens alongside it. A pop on empty is never taken.
    assign pop_ok = i_rd_en && !o_empty;
    assign wr_ok  = i_wr_en && (!o_full || pop_ok);

    uart_fifo_mem #(
        .DataLength (DataLength),
        .Depth      (Depth),
        .AddrWidth  (AddrWidth)
    ) u_mem (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_wr_en    (wr_ok),
        .i_wr_addr  (wr_ptr[AddrWidth-1:0]),
        .i_wr_data  (i_wr_data),
        .i_rd_addr  (rd_ptr[AddrWidth-1:0]),
        .o_rd_data  (o_rd_data)
    );

    // Advance each pointer on an accepted transaction; both wrap mod 2*Depth.
    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Sticky error flags; a set event in the same cycle beats a clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (i_wr_en && !wr_ok) begin
                o_overflow <= 1'b1;
            end else if (i_clear_flags) begin
                o_overflow <= 1'b0;
            end
            if (i_rd_en && o_empty) begin
                o_underflow <= 1'b1;
            end else if (i_clear_flags) begin
                o_underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and random checks of uart_tx_fifo against a queue scoreboard.
module tb_uart_tx_fifo;

    localparam int unsigned DataLength = 8;
    localparam int unsigned Depth      = 16;
    localparam int unsigned AfLevel    = 12;

    logic                  i_clk = 1'b0;
    logic                  i_rst = 1'b1;
    logic [DataLength-1:0] i_wr_data = '0;
    logic                  i_wr_en = 1'b0;
    logic                  i_rd_en = 1'b0;
    logic                  i_clear_flags = 1'b0;
    logic                  o_full;
    logic                  o_almost_full;
    logic [DataLength-1:0] o_rd_data;
    logic                  o_empty;
    logic [4:0]            o_count;
    logic                  o_overflow;
    logic                  o_underflow;

    uart_tx_fifo #(
        .DataLength      (DataLength),
        .Depth           (Depth),
        .AlmostFullLevel (AfLevel)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_wr_data     (i_wr_data),
        .i_wr_en       (i_wr_en),
        .o_full        (o_full),
        .o_almost_full (o_almost_full),
        .o_rd_data     (o_rd_data),
        .o_empty       (o_empty),
        .i_rd_en       (i_rd_en),
        .o_count       (o_count),
        .o_overflow    (o_overflow),
        .o_underflow   (o_underflow),
        .i_clear_flags (i_clear_flags)
    );

    always #5 i_clk = ~i_clk;

    // Reference model
    logic [DataLength-1:0] sb[$];
    logic                  m_ovf = 1'b0;
    logic                  m_udf = 1'b0;
    int                    tests = 0;
    int                    fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every status output (and the head word when non-empty).
    task automatic check_state(input string tag);
        int sz;
        sz = sb.size();
        check({tag, ":count"}, 32'(o_count), 32'(sz));
        check({tag, ":empty"}, 32'(o_empty), 32'(sz == 0));
        check({tag, ":full"},  32'(o_full),  32'(sz == Depth));
        check({tag, ":afull"}, 32'(o_almost_full), 32'(sz >= AfLevel));
        check({tag, ":ovf"},   32'(o_overflow),  32'(m_ovf));
        check({tag, ":udf"},   32'(o_underflow), 32'(m_udf));
        if (sz != 0) begin
            check({tag, ":head"}, 32'(o_rd_data), 32'(sb[0]));
        end
    endtask

    // One clock: drive inputs, pop-compare against the scoreboard, take the
    // edge, update the model, and return #1 after the edge.
    task automatic step(input logic wr, input logic [DataLength-1:0] d,
                        input logic rd, input logic clr);
        logic m_empty, m_full, pop_ok, wr_ok;
        m_empty = (sb.size() == 0);
        m_full  = (sb.size() == Depth);
        pop_ok  = rd && !m_empty;
        wr_ok   = wr && (!m_full || pop_ok);
        i_wr_en = wr;
        i_wr_data = d;
        i_rd_en = rd;
        i_clear_flags = clr;
        #1;
        if (pop_ok) begin
            check("pop_data", 32'(o_rd_data), 32'(sb[0]));
        end
        @(posedge i_clk);
        if (pop_ok) void'(sb.pop_front());
        if (wr_ok) sb.push_back(d);
        if (wr && !wr_ok) m_ovf = 1'b1;
        else if (clr)     m_ovf = 1'b0;
        if (rd && m_empty) m_udf = 1'b1;
        else if (clr)      m_udf = 1'b0;
        #1;
        i_wr_en = 1'b0;
        i_rd_en = 1'b0;
        i_clear_flags = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_bias;
        logic w, r;

        // Reset then idle
        #12;
        i_rst = 1'b0;
        #5;
        check_state("reset");
        check("reset:rd_data", 32'(o_rd_data), 32'h0);

        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("pop_empty:udf", 32'(o_underflow), 32'h1);
        check_state("pop_empty");
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("clear:udf", 32'(o_underflow), 32'h0);

        // Fill 0x00..0x0F
        for (int i = 0; i < Depth; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            check_state("fill");
            if (i == AfLevel - 2) check("fill:afull_low", 32'(o_almost_full), 32'h0);
            if (i == AfLevel - 1) check("fill:afull_high", 32'(o_almost_full), 32'h1);
        end
        check("fill:full", 32'(o_full), 32'h1);

        // 17th write dropped
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        check("overflow:flag", 32'(o_overflow), 32'h1);
        check("overflow:count", 32'(o_count), 32'd16);
        check_state("overflow");

        // Write with pop while full: taken, head advances to 0x01
        step(1'b1, 8'h77, 1'b1, 1'b1);
        check("full_wr_pop:count", 32'(o_count), 32'd16);
        check("full_wr_pop:head", 32'(o_rd_data), 32'h01);
        check("full_wr_pop:ovf_cleared", 32'(o_overflow), 32'h0);
        check_state("full_wr_pop");

        // Drain: 0x01..0x0F then 0x77, checked by the scoreboard on each pop
        for (int i = 0; i < Depth; i++) begin
            if (i == Depth - 1) check("drain:last", 32'(o_rd_data), 32'h77);
            step(1'b0, 8'h00, 1'b1, 1'b0);
            check_state("drain");
        end
        check("drain:empty", 32'(o_empty), 32'h1);

        // Write with pop while empty: write taken, pop ignored
        step(1'b1, 8'h33, 1'b1, 1'b0);
        check("empty_wr_pop:udf", 32'(o_underflow), 32'h1);
        check("empty_wr_pop:count", 32'(o_count), 32'd1);
        check("empty_wr_pop:head", 32'(o_rd_data), 32'h33);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        check_state("empty_wr_pop_out");

        // FWFT latency and head stability
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        check("fwft:head", 32'(o_rd_data), 32'h5A);
        check("fwft:empty", 32'(o_empty), 32'h0);
        for (int i = 0; i < 100; i++) begin
            if (i == 10)      step(1'b1, 8'h11, 1'b0, 1'b0);
            else if (i == 50) step(1'b1, 8'h22, 1'b0, 1'b0);
            else              step(1'b0, 8'h00, 1'b0, 1'b0);
            check("fwft:hold", 32'(o_rd_data), 32'h5A);
        end
        check_state("fwft_hold");
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check_state("fwft_drain");

        // Random interleaved traffic sweeping occupancy across 0..Depth
        for (int i = 0; i < 160; i++) begin
            wr_bias = ((i / 40) % 2 == 0) ? 85 : 15;
            w = ($urandom_range(99) < wr_bias);
            r = ($urandom_range(99) < (100 - wr_bias));
            step(w, 8'($urandom), r, 1'b1);
            check_state("random");
        end

        // Async reset mid-burst at occupancy 9
        while (sb.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
        check("pre_reset:count", 32'(o_count), 32'd9);
        #2;
        i_rst = 1'b1;
        #1;
        sb.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        check_state("async_reset");
        check("async_reset:rd_data", 32'(o_rd_data), 32'h0);
        @(negedge i_clk);
        i_rst = 1'b0;
        step(1'b1, 8'hC3, 1'b0, 1'b0);
        check("post_reset:head", 32'(o_rd_data), 32'hC3);
        check_state("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
